// File: rtl/display_source_arbiter.sv
// display_source_arbiter: fixed-priority (index 0 highest) owner select for the shared 3-digit display.
// Latency: grant/value/blank are registered and update on the clk edge after the triggering req/tick.
// Backpressure: none; requesters hold req as a level, and the owner keeps the display for MIN_DWELL_MS ticks.
// Ports: clk, rst_n (async active-low), tick_1khz (1 kHz strobe), req/blink_req (per source),
//        src_value (12-bit BCD per source), value ({20'b0, BCD}), grant (one-hot owner),
//        busy (not idle), blank (digits off).
// Optional: define BLINK_EN to blink the owner's digits while its blink_req is high; otherwise blank stays 0.
module display_source_arbiter #(
    parameter int          NUM_SRC       = 4,
    parameter int          MIN_DWELL_MS  = 500,
    parameter int          BLINK_HALF_MS = 250,
    parameter logic [11:0] IDLE_VALUE    = 12'h000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_1khz,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [NUM_SRC*12-1:0]  src_value,
    input  logic [NUM_SRC-1:0]     blink_req,
    output logic [31:0]            value,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   busy,
    output logic                   blank
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int DW = (MIN_DWELL_MS > 0) ? $clog2(MIN_DWELL_MS + 1) : 1;
    localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL_MS);
    localparam logic [DW-1:0] DWELL_LAST = (MIN_DWELL_MS > 0) ? DW'(MIN_DWELL_MS - 1) : '0;

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

    // With no dwell a new owner is immediately preemptible.
    localparam state_t GRANT_ST = (MIN_DWELL_MS == 0) ? OPEN : HOLD;

    state_t              state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d, pick;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [11:0]         val_q, val_d, owner_val, pick_val;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic                any_req, hi_req, owner_req, owner_blink, grant_chg;

    // Request decode: priority pick, higher-than-owner request, owner's own lines.
    always_comb begin
        pick        = '0;
        any_req     = 1'b0;
        hi_req      = 1'b0;
        owner_req   = 1'b0;
        owner_blink = 1'b0;
        owner_val   = '0;
        pick_val    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick    = IW'(i);
                any_req = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req[i] && (IW'(i) < owner_q))
                hi_req = 1'b1;
            if (IW'(i) == owner_q) begin
                owner_req   = req[i];
                owner_blink = blink_req[i];
                owner_val   = src_value[12*i +: 12];
            end
            if (IW'(i) == pick)
                pick_val = src_value[12*i +: 12];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state plus next grant/value/dwell
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        val_d     = val_q;
        dwell_d   = dwell_q;
        grant_chg = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = GRANT_ST;
                    owner_d   = pick;
                    grant_d   = NUM_SRC'(1) << pick;
                    val_d     = pick_val;
                    dwell_d   = '0;
                    grant_chg = 1'b1;
                end
            end
            HOLD: begin
                // A released owner keeps its grant; value freezes at the last sample.
                if (owner_req)
                    val_d = owner_val;
                if (tick_1khz) begin
                    if (dwell_q != DWELL_MAX)
                        dwell_d = dwell_q + 1'b1;
                    if (dwell_q == DWELL_LAST)
                        state_d = OPEN;
                end
            end
            OPEN: begin
                if (hi_req || (!owner_req && any_req)) begin
                    // Direct handover, no idle bubble in between.
                    state_d   = GRANT_ST;
                    owner_d   = pick;
                    grant_d   = NUM_SRC'(1) << pick;
                    val_d     = pick_val;
                    dwell_d   = '0;
                    grant_chg = 1'b1;
                end else if (owner_req) begin
                    val_d = owner_val;
                end else begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    val_d     = IDLE_VALUE;
                    grant_chg = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                val_d   = IDLE_VALUE;
            end
        endcase
    end

    // Output comb: busy is a pure decode of the state register.
    always_comb begin
        busy = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= '0;
            grant_q <= '0;
            val_q   <= IDLE_VALUE;
            dwell_q <= '0;
        end else begin
            owner_q <= owner_d;
            grant_q <= grant_d;
            val_q   <= val_d;
            dwell_q <= dwell_d;
        end
    end

    assign grant = grant_q;
    assign value = {20'b0, val_q};

`ifdef BLINK_EN
    localparam int BW = (BLINK_HALF_MS > 0) ? $clog2(BLINK_HALF_MS + 1) : 1;
    localparam logic [BW-1:0] BLINK_LAST = (BLINK_HALF_MS > 0) ? BW'(BLINK_HALF_MS - 1) : '0;

    logic [BW-1:0] blink_cnt_q;
    logic          blank_q;

    // Phase restarts (digits on) on any owner change, in idle, and while blink_req is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (grant_chg || (state_q == IDLE) || !owner_blink) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else if (tick_1khz) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blank_q     <= ~blank_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign blank = blank_q;
`else
    logic blink_unused;
    assign blink_unused = ^{blink_req, owner_blink, grant_chg};
    assign blank        = 1'b0;
`endif

endmodule

// File: tb/tb_display_source_arbiter.sv
// tb_display_source_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: model advances one step per clk posedge; outputs compared at the following negedge.
// Backpressure: n/a (bench drives levels and tick strobes directly).
module tb_display_source_arbiter;

    localparam int          NSRC  = 4;
    localparam int          DWELL = 3;
    localparam int          HALF  = 2;
    localparam logic [11:0] IDLEV = 12'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1khz = 1'b0;
    logic [3:0]  req = '0;
    logic [47:0] src_value = '0;
    logic [3:0]  blink_req = '0;
    logic [31:0] value;
    logic [3:0]  grant;
    logic        busy;
    logic        blank;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = nobody), ticks counted since grant, shown data, blink phase.
    int          m_owner;
    int          m_ticks;
    logic [11:0] m_val;
    logic        m_blank;
    int          m_bcnt;

    display_source_arbiter #(
        .NUM_SRC      (NSRC),
        .MIN_DWELL_MS (DWELL),
        .BLINK_HALF_MS(HALF),
        .IDLE_VALUE   (IDLEV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_1khz(tick_1khz),
        .req      (req),
        .src_value(src_value),
        .blink_req(blink_req),
        .value    (value),
        .grant    (grant),
        .busy     (busy),
        .blank    (blank)
    );

    initial forever #5 clk = ~clk;

    function automatic int lowest(input logic [3:0] r);
        for (int i = 0; i < NSRC; i++)
            if (r[i]) return i;
        return -1;
    endfunction

    function automatic logic [11:0] srcv(input int i);
        return src_value[12*i +: 12];
    endfunction

    function automatic logic [3:0] m_grant();
        logic [3:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ticks = 0;
        m_val   = IDLEV;
        m_blank = 1'b0;
        m_bcnt  = 0;
    endtask

    task automatic set_src(input int i, input logic [11:0] v);
        src_value[12*i +: 12] = v;
    endtask

    // One clock: model consumes the inputs present at the edge; returns at the next negedge.
    task automatic step();
        int p;
        int old;
        @(posedge clk);
        p   = lowest(req);
        old = m_owner;
        if (m_owner < 0) begin
            if (p >= 0) begin
                m_owner = p; m_ticks = 0; m_val = srcv(p);
            end
        end else if (m_ticks < DWELL) begin
            if (req[m_owner]) m_val = srcv(m_owner);
            if (tick_1khz) m_ticks++;
        end else if (p >= 0 && p < m_owner) begin
            m_owner = p; m_ticks = 0; m_val = srcv(p);
        end else if (req[m_owner]) begin
            m_val = srcv(m_owner);
        end else if (p >= 0) begin
            m_owner = p; m_ticks = 0; m_val = srcv(p);
        end else begin
            m_owner = -1; m_val = IDLEV;
        end
        if (m_owner != old || old < 0 || !blink_req[old]) begin
            m_bcnt = 0; m_blank = 1'b0;
        end else if (tick_1khz) begin
            m_bcnt++;
            if (m_bcnt == HALF) begin
                m_bcnt = 0; m_blank = ~m_blank;
            end
        end
`ifndef BLINK_EN
        m_blank = 1'b0;
`endif
        @(negedge clk);
    endtask

    task automatic tick_step();
        tick_1khz = 1'b1;
        step();
        tick_1khz = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; req = '0; blink_req = '0; tick_1khz = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (value !== 32'h0) begin errors++; $display("FAIL reset_value: got %h want 0", value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0001; set_src(0, 12'h555); blink_req = 4'b0001;
        step();
        checks++; if (grant !== 4'b0001 || value !== 32'h555) begin errors++; $display("FAIL reset_first_grant: got %b/%h want 0001/555", grant, value); end
        tick_step(); tick_step(); tick_step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (grant !== 4'b0) begin errors++; $display("FAIL midrun_reset_grant: got %b want 0000", grant); end
        checks++; if (value !== 32'h0 || busy !== 1'b0 || blank !== 1'b0) begin errors++; $display("FAIL midrun_reset_outs: value=%h busy=%b blank=%b want 0/0/0", value, busy, blank); end
        req = '0; blink_req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: grant=%b busy=%b want 0000/0", grant, busy); end
    endtask

    task automatic test_single();
        reset_dut();
        set_src(2, 12'h123); req = 4'b0100;
        step();
        checks++; if (grant !== 4'b0100 || value !== 32'h123) begin errors++; $display("FAIL single_grant: got %b/%h want 0100/123", grant, value); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        set_src(2, 12'h124);
        step();
        checks++; if (value !== 32'h124) begin errors++; $display("FAIL single_track: got %h want 124", value); end
        checks++; if (value !== {20'b0, m_val} || grant !== m_grant()) begin errors++; $display("FAIL single_model: got %b/%h want %b/%h", grant, value, m_grant(), m_val); end
    endtask

    task automatic test_dwell();
        reset_dut();
        set_src(2, 12'h123); set_src(0, 12'h999); req = 4'b0100;
        step();
        tick_step();
        req = 4'b0101;
        tick_step();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL dwell_tick2: got %b want 0100", grant); end
        tick_step();
        checks++; if (grant !== 4'b0100 || value !== 32'h123) begin errors++; $display("FAIL dwell_tick3: got %b/%h want 0100/123", grant, value); end
        step();
        checks++; if (grant !== 4'b0001 || value !== 32'h999) begin errors++; $display("FAIL dwell_preempt: got %b/%h want 0001/999", grant, value); end
    endtask

    task automatic test_release();
        reset_dut();
        set_src(2, 12'h456); req = 4'b0100;
        step();
        tick_step();
        req = 4'b0000; set_src(2, 12'h777);
        step();
        checks++; if (value !== 32'h456 || grant !== 4'b0100) begin errors++; $display("FAIL release_freeze: got %b/%h want 0100/456", grant, value); end
        tick_step(); tick_step();
        checks++; if (value !== 32'h456 || busy !== 1'b1) begin errors++; $display("FAIL release_hold3: value=%h busy=%b want 456/1", value, busy); end
        step();
        checks++; if (grant !== 4'b0 || value !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL release_idle: got %b/%h/%b want 0000/0/0", grant, value, busy); end
    endtask

    task automatic test_handover();
        reset_dut();
        set_src(3, 12'h333); set_src(1, 12'h111); req = 4'b1000;
        step();
        tick_step(); tick_step(); tick_step();
        req = 4'b0010;
        step();
        checks++; if (grant !== 4'b0010 || value !== 32'h111) begin errors++; $display("FAIL handover_grant: got %b/%h want 0010/111", grant, value); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL handover_busy: got %b want 1", busy); end
        tick_step(); tick_step(); tick_step();
        req = 4'b1010;
        step(); step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL low_no_preempt: got %b want 0010", grant); end
    endtask

    task automatic test_blink();
        reset_dut();
        set_src(1, 12'h0ab); set_src(0, 12'h0cd);
        req = 4'b0010; blink_req = 4'b0010;
        step();
        tick_step();
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL blink_t1: got %b want 0", blank); end
        tick_step();
`ifdef BLINK_EN
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL blink_t2: got %b want 1", blank); end
`else
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL blank_tied_t2: got %b want 0", blank); end
`endif
        tick_step();
        checks++; if (blank !== m_blank) begin errors++; $display("FAIL blink_t3: got %b want %b", blank, m_blank); end
        req = 4'b0011; blink_req = 4'b0011;
        step();
        checks++; if (grant !== 4'b0001 || blank !== 1'b0) begin errors++; $display("FAIL blink_grant_change: got %b/%b want 0001/0", grant, blank); end
        tick_step(); tick_step();
        checks++; if (blank !== m_blank) begin errors++; $display("FAIL blink_restart: got %b want %b", blank, m_blank); end
        blink_req = 4'b0000;
        step();
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL blink_req_fall: got %b want 0", blank); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) blink_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) set_src($urandom_range(0, 3), 12'($urandom_range(0, 4095)));
            tick_1khz = ($urandom_range(0, 2) == 0);
            step();
            checks++;
            if (grant !== m_grant() || value !== {20'b0, m_val} || busy !== (m_owner >= 0) || blank !== m_blank) begin
                errors++;
                $display("FAIL random_cycle%0d: grant=%b value=%h busy=%b blank=%b want %b/%h/%b/%b",
                         c, grant, value, busy, blank, m_grant(), m_val, (m_owner >= 0), m_blank);
            end
        end
        tick_1khz = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dwell();
        test_release();
        test_handover();
        test_blink();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
- Shares the 3-digit 7-segment display among NUM_SRC requesters, e.g. score, timer and status message.
- Fixed priority: index 0 is highest.
- A granted source keeps the display for a minimum dwell, so the digits do not flicker.
- Produces the 32-bit BCD `value` word consumed by the display multiplexer.
- Runs on the same `tick_1khz` strobe as the display multiplexer.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- MIN_DWELL_MS, 500, minimum ownership time in tick_1khz pulses (0 = no dwell).
- BLINK_HALF_MS, 250, blink half-period in tick_1khz pulses (only used with BLINK_EN).
- IDLE_VALUE, 12'h000, BCD shown when no source owns the display.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_1khz  in  1  one-cycle 1 kHz strobe.
- req  in  NUM_SRC  level request per source.
- src_value  in  NUM_SRC*12  3-digit BCD per source; source i occupies bits [12i+11:12i].
- blink_req  in  NUM_SRC  per-source blink request; ignored without BLINK_EN.
- value  out  32  {20'b0, selected BCD} to the display.
- grant  out  NUM_SRC  one-hot owner; all zero when idle.
- busy  out  1  high when the state is not IDLE.
- blank  out  1  display blank request (high = digits off).

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE, grant = 0, value = {20'b0, IDLE_VALUE}, busy = 0, blank = 0.
  - Dwell counter = 0, blink counter and phase = 0.
  - Reset mid-ownership drops the grant immediately.
- All outputs are registered.
- Arbitration decisions take effect on the clock edge after the triggering input. `grant` and `value` change on the same edge.
- pick = lowest index i with req[i] = 1.
- States:
  - IDLE:
    - If any req: grant <= onehot(pick), value <= src_value[pick], dwell <= 0.
    - Go to HOLD, or to OPEN if MIN_DWELL_MS = 0.
  - HOLD:
    - On each tick_1khz, dwell increments.
    - A tick with dwell = MIN_DWELL_MS-1 moves the state to OPEN on that edge.
    - No preemption, even by a higher-priority source.
    - While the owner's req = 1, value tracks the owner's src_value every cycle.
    - If the owner drops req, value freezes at its last sampled data and the grant is held until dwell expires.
  - OPEN:
    - Owner req = 1 and no higher-priority req: stay; value keeps tracking.
    - A higher-priority req (index < owner) appears: switch to it next edge, reset dwell, go to HOLD.
    - Owner req = 0 and another req pending: grant pick next edge, reset dwell, go to HOLD. There is no IDLE bubble.
    - Owner req = 0 and nothing pending: go to IDLE, grant <= 0, value <= {20'b0, IDLE_VALUE}.
    - Lower-priority requests never preempt.
- Ticks that arrive in the same cycle as a grant change do not count toward dwell.
- Dwell counter width: enough bits for MIN_DWELL_MS; it saturates and does not wrap.
- src_value is passed through unchecked; non-BCD nibbles go to the display as is.
- Dwell expiring and the owner dropping req in the same cycle: HOLD->OPEN, then the OPEN rules apply next cycle (one extra cycle of frozen value).

Optional Feature:
- Macro: BLINK_EN.
- Defined:
  - While the owner's blink_req = 1, a blink counter counts tick_1khz up to BLINK_HALF_MS.
  - Each time it reaches BLINK_HALF_MS it toggles blank and clears.
  - The counter restarts with blank = 0 on every grant change and whenever the owner's blink_req falls.
  - blank = 0 in IDLE.
- Undefined: blank is tied to 0, blink_req is unused, and no blink counter is synthesised.

Test Plan (MIN_DWELL_MS=3, BLINK_HALF_MS=2, NUM_SRC=4, IDLE_VALUE=12'h000):
- Reset then idle: rst_n low mid-run -> grant=0, value=32'h0, busy=0, blank=0 immediately.
- Single request: req=4'b0100 with src_value[2]=12'h123 -> next edge grant=4'b0100, value=32'h123. src_value[2] changes to 12'h124 -> value=32'h124 one cycle later.
- Dwell blocks preemption:
  - req[2] is granted, then req[0] rises (src_value[0]=12'h999) after 1 tick -> grant stays 4'b0100 until the 3rd tick.
  - The next edge then gives grant=4'b0001, value=32'h999.
- Early release freezes value: owner drops req after 1 tick -> value holds last data, grant held; after the 3rd tick with no other req -> IDLE, value=32'h0.
- Handover without bubble: owner 3 in OPEN drops req while req[1]=1 -> next edge grant=4'b0010, busy stays 1. A lower-priority req[3] rising while owner 1 is in OPEN -> no change.
- BLINK_EN: owner with blink_req=1 -> blank toggles every 2 ticks (0,0,1,1,0...). Grant change -> blank=0 and the counter restarts.
